// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states, timing defaults.
// Pure declarations, no logic or latency of its own.
// No flow control here; consumers own all handshaking.
package md_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_MULT  = 3'd0;
    localparam md_op_t MD_MULTU = 3'd1;
    localparam md_op_t MD_DIV   = 3'd2;
    localparam md_op_t MD_DIVU  = 3'd3;
    localparam md_op_t MD_MTHI  = 3'd4;
    localparam md_op_t MD_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/md_if.sv
// Issue/result bundle between the Execute/Decode stages and the HI/LO sequencer.
// Pure wiring, zero latency.
// stall is the only backpressure; the E side must not issue while busy.
interface md_if;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        cancel;
    logic        md_use_d;
    logic        stall;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output md_valid, md_op, rs_data, rt_data, cancel, md_use_d,
        input  stall, busy, hi_out, lo_out
    );

    modport slave (
        input  md_valid, md_op, rs_data, rt_data, cancel, md_use_d,
        output stall, busy, hi_out, lo_out
    );
endinterface

// File: rtl/md_arith.sv
// Combinational 32x32 multiply / divide producing the {hi,lo} pair plus a divide-by-zero flag.
// Zero latency; the sequencer supplies the multi-cycle timing.
// No backpressure; result is valid whenever inputs are.
module md_arith
    import md_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] res,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] mag_rs;
    logic [31:0] mag_rt;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u = {32'd0, rs} * {32'd0, rt};

        // Work on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without relying on tool overflow behaviour.
        div_signed = (op == MD_DIV);
        mag_rs     = (div_signed && rs[31]) ? (32'd0 - rs) : rs;
        mag_rt     = (div_signed && rt[31]) ? (32'd0 - rt) : rt;
        divisor    = (mag_rt == 32'd0) ? 32'd1 : mag_rt;
        quo        = mag_rs / divisor;
        rem        = mag_rs % divisor;
        if (div_signed && (rs[31] ^ rt[31])) quo = 32'd0 - quo;
        if (div_signed && rs[31])            rem = 32'd0 - rem;

        div0 = ((op == MD_DIV) || (op == MD_DIVU)) && (rt == 32'd0);

        case (op)
            MD_MULT:         res = prod_s;
            MD_MULTU:        res = prod_u;
            MD_DIV, MD_DIVU: res = {rem, quo};
            default:         res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO sequencer: issues mult/div/mthi/mtlo, counts down the shared unit's latency, commits HI/LO.
// mthi/mtlo land at the issue edge; mult/div commit N cycles later (N = MULT_CYCLES / DIV_CYCLES).
// Holds Decode via stall while busy; optional MD_DIV0_FAST_EN finishes divide-by-zero in one cycle.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic clk,
    input logic reset_n,
    md_if.slave md
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             div0_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      temp_hi_q;
    logic [31:0]      temp_lo_q;

    logic [63:0]      arith_res;
    logic             arith_div0;
    logic             issue;
    logic [CNT_W-1:0] div_load;

    md_arith u_arith (
        .op   (md.md_op),
        .rs   (md.rs_data),
        .rt   (md.rt_data),
        .res  (arith_res),
        .div0 (arith_div0)
    );

    assign issue = md.md_valid & ~md.cancel & (state_q == IDLE);

`ifdef MD_DIV0_FAST_EN
    assign div_load = arith_div0 ? '0 : DIV_LOAD;
`else
    assign div_load = DIV_LOAD;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            temp_hi_q <= '0;
            temp_lo_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        case (md.md_op)
                            MD_MTHI: hi_q <= md.rs_data;
                            MD_MTLO: lo_q <= md.rs_data;
                            MD_MULT, MD_MULTU: begin
                                {temp_hi_q, temp_lo_q} <= arith_res;
                                div0_q  <= 1'b0;
                                cnt_q   <= MULT_LOAD;
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                {temp_hi_q, temp_lo_q} <= arith_res;
                                div0_q  <= arith_div0;
                                cnt_q   <= div_load;
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // cancel is deliberately ignored here: the issuer is already past the exception point.
                    if (cnt_q == '0) begin
                        if (!div0_q) begin
                            hi_q <= temp_hi_q;
                            lo_q <= temp_lo_q;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md.busy   = busy_q;
    assign md.hi_out = hi_q;
    assign md.lo_out = lo_q;
    assign md.stall  = reset_n & md.md_use_d &
                       (busy_q | (md.md_valid & ~md.cancel & (md.md_op <= MD_DIVU)));

    md_valid_while_busy: assert property (@(posedge clk) disable iff (!reset_n)
        !(md.md_valid && busy_q));

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: arithmetic results, busy/stall timing, cancel, reserved ops and mid-run reset.
module tb_md_ctrl;
    import md_pkg::*;

`ifdef MD_DIV0_FAST_EN
    localparam int DIV0_CYC = 1;
`else
    localparam int DIV0_CYC = 10;
`endif

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    md_if mdi ();

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (mdi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        mdi.md_valid = 1'b1;
        mdi.md_op    = op;
        mdi.rs_data  = rs;
        mdi.rt_data  = rt;
        @(negedge clk);
        mdi.md_valid = 1'b0;
    endtask

    // Counts busy cycles from the first post-issue negedge; stops on the first idle negedge.
    task automatic run_len(output int cyc);
        cyc = 0;
        while (mdi.busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int scnt;
        n_cmp = 0;
        n_err = 0;
        reset_n      = 1'b0;
        mdi.md_valid = 1'b1;
        mdi.md_op    = MD_MULT;
        mdi.rs_data  = 32'd0;
        mdi.rt_data  = 32'd0;
        mdi.cancel   = 1'b0;
        mdi.md_use_d = 1'b1;

        @(negedge clk);
        chk("rst_busy",  {31'd0, mdi.busy},  32'd0);
        chk("rst_stall", {31'd0, mdi.stall}, 32'd0);
        chk("rst_hi",    mdi.hi_out, 32'd0);
        chk("rst_lo",    mdi.lo_out, 32'd0);
        mdi.md_valid = 1'b0;
        mdi.md_use_d = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
        run_len(cyc);
        chk("mult_cyc", cyc, 32'd5);
        chk("mult_hi", mdi.hi_out, 32'hFFFF_FFFF);
        chk("mult_lo", mdi.lo_out, 32'hFFFF_FFF1);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        run_len(cyc);
        chk("multu_cyc", cyc, 32'd5);
        chk("multu_hi", mdi.hi_out, 32'h0000_0001);
        chk("multu_lo", mdi.lo_out, 32'hFFFF_FFFE);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        run_len(cyc);
        chk("div_cyc", cyc, 32'd10);
        chk("div_hi", mdi.hi_out, 32'hFFFF_FFFF);
        chk("div_lo", mdi.lo_out, 32'hFFFF_FFFD);

        issue(MD_DIVU, 32'd7, 32'd2);
        run_len(cyc);
        chk("divu_hi", mdi.hi_out, 32'd1);
        chk("divu_lo", mdi.lo_out, 32'd3);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_len(cyc);
        chk("divovf_hi", mdi.hi_out, 32'd0);
        chk("divovf_lo", mdi.lo_out, 32'h8000_0000);

        issue(MD_MTHI, 32'h0000_1234, 32'd0);
        chk("mthi_busy", {31'd0, mdi.busy}, 32'd0);
        chk("mthi_hi", mdi.hi_out, 32'h0000_1234);
        issue(MD_MTLO, 32'h0000_5678, 32'd0);
        chk("mtlo_lo", mdi.lo_out, 32'h0000_5678);

        issue(MD_DIVU, 32'd9, 32'd0);
        run_len(cyc);
        chk("div0_cyc", cyc, DIV0_CYC);
        chk("div0_hi", mdi.hi_out, 32'h0000_1234);
        chk("div0_lo", mdi.lo_out, 32'h0000_5678);

        // Cancelled issue must leave no trace.
        @(negedge clk);
        mdi.md_valid = 1'b1;
        mdi.md_op    = MD_MULT;
        mdi.rs_data  = 32'd9;
        mdi.rt_data  = 32'd9;
        mdi.cancel   = 1'b1;
        mdi.md_use_d = 1'b1;
        #1;
        chk("cancel_stall", {31'd0, mdi.stall}, 32'd0);
        @(negedge clk);
        mdi.md_valid = 1'b0;
        mdi.cancel   = 1'b0;
        mdi.md_use_d = 1'b0;
        chk("cancel_busy", {31'd0, mdi.busy}, 32'd0);
        chk("cancel_lo", mdi.lo_out, 32'h0000_5678);

        issue(3'd6, 32'hDEAD_BEEF, 32'd1);
        chk("rsvd_busy", {31'd0, mdi.busy}, 32'd0);
        chk("rsvd_hi", mdi.hi_out, 32'h0000_1234);
        chk("rsvd_lo", mdi.lo_out, 32'h0000_5678);

        // cancel arriving after issue does not abort the run.
        issue(MD_MULT, 32'd6, 32'd7);
        mdi.cancel = 1'b1;
        @(negedge clk);
        mdi.cancel = 1'b0;
        run_len(cyc);
        chk("runcancel_cyc", cyc, 32'd4);
        chk("runcancel_hi", mdi.hi_out, 32'd0);
        chk("runcancel_lo", mdi.lo_out, 32'd42);

        @(negedge clk);
        mdi.md_valid = 1'b1;
        mdi.md_op    = MD_MULT;
        mdi.rs_data  = 32'd3;
        mdi.rt_data  = 32'd4;
        mdi.md_use_d = 1'b1;
        #1;
        chk("stall_issue", {31'd0, mdi.stall}, 32'd1);
        @(negedge clk);
        mdi.md_valid = 1'b0;
        scnt = 0;
        cyc  = 0;
        while (mdi.busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (mdi.stall === 1'b1) scnt++;
            @(negedge clk);
        end
        chk("stall_cycles", scnt, 32'd5);
        chk("stall_release", {31'd0, mdi.stall}, 32'd0);
        chk("stall_lo", mdi.lo_out, 32'd12);
        mdi.md_use_d = 1'b0;

        issue(MD_DIV, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_busy3", {31'd0, mdi.busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, mdi.busy}, 32'd0);
        chk("rstmid_hi", mdi.hi_out, 32'd0);
        chk("rstmid_lo", mdi.lo_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(MD_MTLO, 32'h0000_ABCD, 32'd0);
        chk("post_rst_lo", mdi.lo_out, 32'h0000_ABCD);
        chk("post_rst_hi", mdi.hi_out, 32'd0);
        repeat (12) @(negedge clk);
        chk("post_rst_idle", {31'd0, mdi.busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule
